sid_note_sequencer: RTL and testbench

- Autonomous note sequencer that drives the SID voice's frequency and waveform/gate registers from a small programmable note table.
- Sits between the SPI register bank and sid_voice.
  - Firmware loads notes and tempo once.
  - The block then steps through the table, gating each note on for a programmed number of tempo ticks, followed by a one-tick release gap so ADSR retriggers.

---
 rtl/sid_seq_pkg.sv | 29 ++
 rtl/seq_tick_gen.sv | 28 ++
 rtl/sid_note_sequencer.sv | 131 +++++++++++++
 tb/tb_sid_note_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_seq_pkg.sv
// Shared types and note-entry field layout for the SID note sequencer.
// Optional octave transpose is enabled with `define SEQ_TRANSPOSE_EN.
package sid_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_GATE_ON  = 2'd2,
        S_GATE_OFF = 2'd3
    } seq_state_t;

    localparam int ENTRY_W  = 24;
    localparam int FREQ_MSB = 23;
    localparam int FREQ_LSB = 8;
    localparam int WAVE_MSB = 7;
    localparam int WAVE_LSB = 4;
    localparam int LEN_MSB  = 3;
    localparam int LEN_LSB  = 0;
    localparam int GATE_BIT = 0;

    // Shift left by whole octaves, saturating instead of wrapping.
    function automatic logic [15:0] transpose_freq(input logic [15:0] freq,
                                                   input logic [1:0]  oct);
        logic [18:0] wide;
        wide = {3'b000, freq} << oct;
        return (|wide[18:16]) ? 16'hFFFF : wide[15:0];
    endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Tempo tick generator: counts 0..tempo and pulses tick on the terminal count.
// Not affected by SEQ_TRANSPOSE_EN.
module seq_tick_gen
    import sid_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] tempo,
    output logic        tick
);

    logic [15:0] cnt;

    // Compare is live, so a tempo change applies from the next comparison.
    assign tick = (cnt == tempo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sid_note_sequencer.sv
// Steps through a programmable note table driving SID frequency and waveform/gate.
// `define SEQ_TRANSPOSE_EN adds a transpose input that shifts notes by octaves.
//
// state      | meaning
// S_IDLE     | not playing, waiting for start
// S_LOAD     | read entry[step]; end marker wraps or stops, else load note
// S_GATE_ON  | gate high, count down len ticks
// S_GATE_OFF | one-tick release gap, then advance step
module sid_note_sequencer
    import sid_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [23:0]        cfg_wdata,
    input  logic [15:0]        tempo,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
`ifdef SEQ_TRANSPOSE_EN
    input  logic [1:0]         transpose,
`endif
    output logic [15:0]        sid_frequency,
    output logic [7:0]         sid_waveform,
    output logic               busy,
    output logic [ADDR_W-1:0]  step,
    output logic               step_strobe
);

    seq_state_t         state;
    logic [ENTRY_W-1:0] note_mem [DEPTH];
    logic [ENTRY_W-1:0] entry;
    logic [3:0]         entry_len;
    logic [15:0]        entry_freq;
    logic [15:0]        load_freq;
    logic [3:0]         remaining;
    logic               tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) note_mem[i] <= '0;
        end else if (cfg_we) begin
            note_mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign entry      = note_mem[step];
    assign entry_len  = entry[LEN_MSB:LEN_LSB];
    assign entry_freq = entry[FREQ_MSB:FREQ_LSB];

`ifdef SEQ_TRANSPOSE_EN
    assign load_freq = transpose_freq(entry_freq, transpose);
`else
    assign load_freq = entry_freq;
`endif

    // Holding the counter clear through LOAD guarantees GATE_ON starts at zero.
    seq_tick_gen u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_LOAD),
        .tempo (tempo),
        .tick  (tick)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            step          <= '0;
            remaining     <= '0;
            sid_frequency <= '0;
            sid_waveform  <= '0;
            step_strobe   <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            if (stop) begin
                state                  <= S_IDLE;
                sid_waveform[GATE_BIT] <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            step  <= '0;
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (entry_len == 4'd0) begin
                            if (loop_en && (step != '0)) step  <= '0;
                            else                         state <= S_IDLE;
                        end else begin
                            sid_frequency <= load_freq;
                            sid_waveform  <= {entry[WAVE_MSB:WAVE_LSB], 3'b000, 1'b1};
                            remaining     <= entry_len;
                            step_strobe   <= 1'b1;
                            state         <= S_GATE_ON;
                        end
                    end
                    S_GATE_ON: begin
                        if (tick) begin
                            remaining <= remaining - 4'd1;
                            if (remaining == 4'd1) begin
                                sid_waveform[GATE_BIT] <= 1'b0;
                                state                  <= S_GATE_OFF;
                            end
                        end
                    end
                    S_GATE_OFF: begin
                        if (tick) begin
                            if (step == ADDR_W'(DEPTH - 1)) begin
                                step  <= '0;
                                state <= loop_en ? S_LOAD : S_IDLE;
                            end else begin
                                step  <= step + ADDR_W'(1);
                                state <= S_LOAD;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sid_note_sequencer.sv
// Directed self-checking bench for sid_note_sequencer.
// Covers the SEQ_TRANSPOSE_EN cases when that macro is defined.
module tb_sid_note_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic [15:0] tempo;
    logic        start;
    logic        stop;
    logic        loop_en;
`ifdef SEQ_TRANSPOSE_EN
    logic [1:0]  transpose;
`endif
    logic [15:0] sid_frequency;
    logic [7:0]  sid_waveform;
    logic        busy;
    logic [2:0]  step;
    logic        step_strobe;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    logic [2:0] step_q[$];

    sid_note_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .tempo         (tempo),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
`ifdef SEQ_TRANSPOSE_EN
        .transpose     (transpose),
`endif
        .sid_frequency (sid_frequency),
        .sid_waveform  (sid_waveform),
        .busy          (busy),
        .step          (step),
        .step_strobe   (step_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_strobe) begin
            strobe_cnt++;
            step_q.push_back(step);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_note(input logic [2:0] s, input string tag);
        int n;
        for (n = 0; n < 300 && !(step == s && step_strobe); n++) cyc(1);
        if (!(step == s && step_strobe)) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int q0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        tempo = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
`ifdef SEQ_TRANSPOSE_EN
        transpose = 2'd0;
`endif
        #1;
        check("rst_freq", 32'(sid_frequency), 32'h0);
        check("rst_wave", 32'(sid_waveform), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // basic note: len 2, tempo 3 -> 8 gate-high cycles
        tempo = 16'd3;
        wr(3'd0, {16'h1CD6, 4'h1, 4'd2});
        s0 = strobe_cnt;
        pulse_start();
        check("basic_load_busy", 32'(busy), 32'h1);
        check("basic_load_strobe", 32'(step_strobe), 32'h0);
        cyc(1);
        check("basic_freq", 32'(sid_frequency), 32'h1CD6);
        check("basic_wave_on", 32'(sid_waveform), 32'h11);
        check("basic_strobe", 32'(step_strobe), 32'h1);
        for (int k = 1; k < 8; k++) begin
            cyc(1);
            check("basic_gate_held", 32'(sid_waveform), 32'h11);
        end
        cyc(1);
        check("basic_wave_off", 32'(sid_waveform), 32'h10);
        cyc(3);
        check("basic_gap_busy", 32'(busy), 32'h1);
        cyc(1);
        check("basic_next_step", 32'(step), 32'h1);
        cyc(1);
        check("basic_idle", 32'(busy), 32'h0);
        check("basic_freq_held", 32'(sid_frequency), 32'h1CD6);
        check("basic_wave_held", 32'(sid_waveform), 32'h10);
        check("basic_strobe_count", 32'(strobe_cnt - s0), 32'd1);

        // loop over three notes
        do_reset();
        tempo = 16'd0; loop_en = 1'b1;
        wr(3'd0, {16'h0A00, 4'h2, 4'd1});
        wr(3'd1, {16'h0B00, 4'h2, 4'd1});
        wr(3'd2, {16'h0C00, 4'h2, 4'd1});
        q0 = step_q.size();
        pulse_start();
        cyc(40);
        check("loop_busy", 32'(busy), 32'h1);
        check("loop_enough_notes", 32'(step_q.size() - q0 >= 7), 32'h1);
        for (int i = 0; i < 7; i++) begin
            if (q0 + i < step_q.size())
                check("loop_step_seq", 32'(step_q[q0 + i]), 32'(i % 3));
        end
        pulse_stop();
        check("loop_stop_busy", 32'(busy), 32'h0);

        // stop mid-note, then start+stop together
        do_reset();
        tempo = 16'd1; loop_en = 1'b0;
        wr(3'd0, {16'h1111, 4'h3, 4'd4});
        wr(3'd1, {16'h2222, 4'h5, 4'd4});
        pulse_start();
        wait_note(3'd1, "stop_reach_entry1");
        cyc(2);
        check("stop_pre_gate", 32'(sid_waveform), 32'h51);
        pulse_stop();
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_wave", 32'(sid_waveform), 32'h50);
        check("stop_freq", 32'(sid_frequency), 32'h2222);
        s0 = strobe_cnt;
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'h0);
        cyc(2);
        check("startstop_idle", 32'(busy), 32'h0);
        check("startstop_strobes", 32'(strobe_cnt - s0), 32'd0);

        // full table end, no loop then loop
        do_reset();
        tempo = 16'd0; loop_en = 1'b0;
        for (int i = 0; i < 8; i++) wr(3'(i), {16'(16'h0100 * (i + 1)), 4'h4, 4'd1});
        pulse_start();
        wait_note(3'd7, "end_reach_7");
        check("end_freq7", 32'(sid_frequency), 32'h0800);
        cyc(1);
        check("end_gate_off", 32'(sid_waveform), 32'h40);
        check("end_gap_busy", 32'(busy), 32'h1);
        cyc(1);
        check("end_idle", 32'(busy), 32'h0);
        check("end_step_wrap", 32'(step), 32'h0);
        check("end_gate", 32'(sid_waveform[0]), 32'h0);
        loop_en = 1'b1;
        pulse_start();
        wait_note(3'd7, "wrap_reach_7");
        cyc(2);
        check("wrap_busy", 32'(busy), 32'h1);
        check("wrap_step", 32'(step), 32'h0);
        cyc(1);
        check("wrap_strobe", 32'(step_strobe), 32'h1);
        check("wrap_freq", 32'(sid_frequency), 32'h0100);
        pulse_stop();

        // empty table
        do_reset();
        loop_en = 1'b1;
        s0 = strobe_cnt;
        pulse_start();
        check("empty_load", 32'(busy), 32'h1);
        cyc(1);
        check("empty_idle", 32'(busy), 32'h0);
        check("empty_strobes", 32'(strobe_cnt - s0), 32'd0);

        // asynchronous reset mid-note
        loop_en = 1'b0; tempo = 16'd2;
        wr(3'd0, {16'hABCD, 4'h2, 4'd5});
        pulse_start();
        cyc(3);
        check("arst_pre_wave", 32'(sid_waveform), 32'h21);
        rst = 1'b1;
        #1;
        check("arst_freq", 32'(sid_frequency), 32'h0);
        check("arst_wave", 32'(sid_waveform), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_step", 32'(step), 32'h0);
        rst = 1'b0;
        cyc(1);

`ifdef SEQ_TRANSPOSE_EN
        tempo = 16'd0;
        wr(3'd0, {16'h4000, 4'h1, 4'd1});
        transpose = 2'd2;
        pulse_start();
        cyc(1);
        check("xpose_saturate", 32'(sid_frequency), 32'hFFFF);
        pulse_stop();
        wr(3'd0, {16'h0100, 4'h1, 4'd1});
        transpose = 2'd3;
        pulse_start();
        cyc(1);
        check("xpose_shift3", 32'(sid_frequency), 32'h0800);
        pulse_stop();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
